systolic_result_collector: RTL
==============================

# systolic_result_collector

Synthesizable, double-buffered result collector for the systolic array's D outputs. Captures the N1 per-row result lanes under `valid_D`, assembles complete M×M result matrices in two ping-pong banks, and drains each finished matrix as a single valid/ready word stream. Sits between the `systolic` core and the downstream store or DMA, and lets the array start the next matrix while the previous one is being read out.

## Interface
- `D_W_ACC`, 16: result word width.
- `N1`, 4: number of result lanes (array rows). Must divide M*M.
- `M`, 8: matrix dimension. `LANE_WORDS = M*M/N1` is derived.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `D`  in  N1*D_W_ACC  packed lane results; lane x occupies bits [x*D_W_ACC +: D_W_ACC].
- `valid_D`  in  N1  per-lane write strobe.
- `wr_ready`  out  1  high while at least one bank is not full.
- `frame_done`  out  1  one-cycle pulse when a bank becomes full.
- `overflow`  out  1  sticky; set when a lane write is dropped.
- `out_data`  out  D_W_ACC  drained word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  marks the final word of a matrix.

## Operation
- Two banks, each holding M*M words. Within a bank, lane x owns addresses x*LANE_WORDS to (x+1)*LANE_WORDS-1.
- Per-lane state:
  - `waddr[x]` runs 0 to LANE_WORDS-1 and wraps to 0.
  - `wbank[x]` is the bank the lane is currently writing.
- Write: when `valid_D[x]`=1 and `wbank[x]` is not full, store `D[x]` at bank `wbank[x]`, address x*LANE_WORDS+`waddr[x]`, then increment `waddr[x]`.
- Lane completion: on the write at `waddr[x]`=LANE_WORDS-1, set `done_mask[wbank[x]][x]` and toggle `wbank[x]`. Lanes are skewed, so early lanes may begin filling the other bank before late lanes finish.
- Bank full: when `done_mask[b]` is all ones, set `full[b]`, clear `done_mask[b]`, and pulse `frame_done`.
- Dropped write: a write aimed at a full bank is discarded and `overflow` is set. `waddr` and `wbank` do not advance.
- Drain: a read pointer `rb` starts at 0.
  - When `full[rb]`=1, emit words k = 0..M*M-1 in row-major order (address k).
  - After the `out_last` word is accepted, clear `full[rb]` and toggle `rb`.
- Output stage: a one-entry registered output plus one prefetch read. Sustains one word per cycle while `out_ready`=1.
- Simultaneous events:
  - A drain releasing bank b and a lane write to b in the same cycle: the write uses the pre-edge `full` value and is dropped (overflow).
  - `frame_done` for both banks in the same cycle cannot occur. An assertion checks this.
- Reset (asserted at any time, including mid-frame or mid-drain) clears counters, masks, `full`, `wbank`, `rb` and all outputs. Bank RAM contents are not reset.

## Timing
- Reset values: `wr_ready`=1; `frame_done`, `overflow`, `out_valid`, `out_last`=0; `out_data`=0.
- Write latency: the word is stored on the edge that samples `valid_D`.
- `frame_done` is high in the cycle after the edge that stores the final lane word.
- `out_valid` rises 2 cycles after `frame_done`, or 2 cycles after `rb` toggles onto an already-full bank.
- Handshake: a word transfers on an edge with `out_valid`&`out_ready`. While `out_ready`=0, `out_data`, `out_valid` and `out_last` hold stable.
- `wr_ready` is combinational from the registered `full` flags.
- `full[rb]` clears on the edge that accepts the last word. That bank is writable from the next cycle.

## Configuration
- `SYSTOLIC_COLLECT_TRANSPOSE_EN`:
  - Defined: the drain emits column-major order, word j = address (j mod M)*M + j/M, so the stream is Dᵀ.
  - Undefined: row-major order only; no transpose address logic is built.
- Write path, handshake and latencies are identical in both builds.

## Test plan
- N1=4, M=8, all lanes strobed together with D=lane*100+index, `out_ready`=1 → `frame_done` after 16 writes; 64 words out in row-major order; `out_last` on word 63.
- Lane x delayed by x cycles (systolic skew), back-to-back matrices → second matrix lands in bank 1 with no drops; `overflow`=0; streams are contiguous.
- Three matrices written with `out_ready`=0 → `wr_ready` falls after the second `frame_done`; third-matrix writes set `overflow`; the first two matrices drain intact.
- Random `out_ready` toggling during drain → every word is emitted exactly once; data holds stable while stalled.
- `rst_n` pulsed low mid-drain at word 20 → outputs go to 0 asynchronously; after release, a fresh matrix drains from word 0.
- With `SYSTOLIC_COLLECT_TRANSPOSE_EN` defined, D[r][c]=r*8+c → stream is 0, 8, 16, …, 56, 1, 9, …

Source files
------------

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: gathers the N1 per-row result lanes of the
// systolic array into two ping-pong banks of M*M words and drains each
// finished matrix as one valid/ready word stream.
// Build option: define SYSTOLIC_COLLECT_TRANSPOSE_EN to drain column-major
// (the stream becomes the transposed matrix); otherwise row-major only.
module systolic_result_collector #(
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned N1      = 4,
  parameter int unsigned M       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N1*D_W_ACC-1:0]  D,
  input  logic [N1-1:0]          valid_D,
  output logic                   wr_ready,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [D_W_ACC-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int unsigned MM         = M * M;
  localparam int unsigned LANE_WORDS = MM / N1;
  localparam int unsigned LAW        = (LANE_WORDS > 1) ? $clog2(LANE_WORDS) : 1;
  localparam int unsigned KW         = (MM > 1) ? $clog2(MM) : 1;
  localparam int unsigned LNW        = (N1 > 1) ? $clog2(N1) : 1;

  // Bank storage, split per lane so every lane can write in the same cycle
  logic [D_W_ACC-1:0] mem_q [2][N1][LANE_WORDS];

  logic [N1-1:0][LAW-1:0] waddr_q, waddr_d;
  logic [N1-1:0]          wbank_q, wbank_d;
  logic [1:0][N1-1:0]     done_mask_q, done_mask_d;
  logic [1:0]             full_q, full_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;
  logic [N1-1:0]          wr_en_c;
  logic [1:0]             bank_cmp_c;

  logic                   rb_q, rb_d;
  logic [KW-1:0]          rcnt_q, rcnt_d;
  logic                   issued_q, issued_d;
  logic                   pv_q, pv_d;
  logic [D_W_ACC-1:0]     pdata_q, pdata_d;
  logic                   plast_q, plast_d;
  logic                   ov_q, ov_d;
  logic [D_W_ACC-1:0]     od_q, od_d;
  logic                   ol_q, ol_d;

  logic                   o_load_c, p_load_c, issue_c, rel_c;
  logic [KW-1:0]          raddr_c;
  logic [LNW-1:0]         rd_lane_c;
  logic [LAW-1:0]         rd_off_c;

  assign wr_ready   = ~(full_q[0] & full_q[1]);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign out_data   = od_q;
  assign out_valid  = ov_q;
  assign out_last   = ol_q;

  // Lane write bookkeeping, bank completion and full-flag update
  always_comb begin
    waddr_d      = waddr_q;
    wbank_d      = wbank_q;
    done_mask_d  = done_mask_q;
    full_d       = full_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_en_c      = '0;
    bank_cmp_c   = '0;
    for (int x = 0; x < int'(N1); x++) begin
      if (valid_D[x]) begin
        if (full_q[wbank_q[x]]) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_c[x] = 1'b1;
          if (waddr_q[x] == LAW'(LANE_WORDS - 1)) begin
            waddr_d[x]                  = '0;
            done_mask_d[wbank_q[x]][x]  = 1'b1;
            wbank_d[x]                  = ~wbank_q[x];
          end else begin
            waddr_d[x] = waddr_q[x] + LAW'(1);
          end
        end
      end
    end
    if (rel_c) full_d[rb_q] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (&done_mask_d[b]) begin
        bank_cmp_c[b]  = 1'b1;
        full_d[b]      = 1'b1;
        done_mask_d[b] = '0;
        frame_done_d   = 1'b1;
      end
    end
  end

  // Drain read address: row-major, or column-major when transposing
  always_comb begin
`ifdef SYSTOLIC_COLLECT_TRANSPOSE_EN
    raddr_c = KW'((rcnt_q % KW'(M)) * KW'(M) + rcnt_q / KW'(M));
`else
    raddr_c = rcnt_q;
`endif
    rd_lane_c = LNW'(raddr_c / KW'(LANE_WORDS));
    rd_off_c  = LAW'(raddr_c % KW'(LANE_WORDS));
  end

  // Prefetch stage feeding a one-entry output register
  always_comb begin
    pv_d     = pv_q;
    pdata_d  = pdata_q;
    plast_d  = plast_q;
    ov_d     = ov_q;
    od_d     = od_q;
    ol_d     = ol_q;
    rcnt_d   = rcnt_q;
    issued_d = issued_q;
    rb_d     = rb_q;
    o_load_c = ~ov_q | out_ready;
    p_load_c = ~pv_q | o_load_c;
    issue_c  = full_q[rb_q] & ~issued_q & p_load_c;
    rel_c    = ov_q & out_ready & ol_q;
    if (o_load_c) begin
      ov_d = pv_q;
      if (pv_q) begin
        od_d = pdata_q;
        ol_d = plast_q;
      end else begin
        ol_d = 1'b0;
      end
    end
    if (p_load_c) begin
      pv_d = issue_c;
      if (issue_c) begin
        pdata_d = mem_q[rb_q][rd_lane_c][rd_off_c];
        plast_d = (rcnt_q == KW'(MM - 1));
        if (rcnt_q == KW'(MM - 1)) begin
          rcnt_d   = '0;
          issued_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + KW'(1);
        end
      end
    end
    if (rel_c) begin
      rb_d     = ~rb_q;
      issued_d = 1'b0;
    end
  end

  // Control and output state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q      <= '0;
      wbank_q      <= '0;
      done_mask_q  <= '0;
      full_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      rb_q         <= 1'b0;
      rcnt_q       <= '0;
      issued_q     <= 1'b0;
      pv_q         <= 1'b0;
      pdata_q      <= '0;
      plast_q      <= 1'b0;
      ov_q         <= 1'b0;
      od_q         <= '0;
      ol_q         <= 1'b0;
    end else begin
      waddr_q      <= waddr_d;
      wbank_q      <= wbank_d;
      done_mask_q  <= done_mask_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      rb_q         <= rb_d;
      rcnt_q       <= rcnt_d;
      issued_q     <= issued_d;
      pv_q         <= pv_d;
      pdata_q      <= pdata_d;
      plast_q      <= plast_d;
      ov_q         <= ov_d;
      od_q         <= od_d;
      ol_q         <= ol_d;
    end
  end

  // Bank RAM writes; contents are intentionally not reset
  for (genvar g = 0; g < int'(N1); g++) begin : g_lane_wr
    always_ff @(posedge clk) begin
      if (wr_en_c[g]) mem_q[wbank_q[g]][g][waddr_q[g]] <= D[g*D_W_ACC +: D_W_ACC];
    end
  end

  // Both banks completing in one cycle would mean a lane outran a whole bank
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(bank_cmp_c[0] && bank_cmp_c[1]));
  end

endmodule
